// File: rtl/score_matrix_stream_pkg.sv
// Shared types and width helpers for the score matrix streamer.
// SCORE_ROW_SUM_EN widens rd_sum via sumw().
package score_pkg;

  typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} score_state_e;

  function automatic int ciw(input int cols);
    return ($clog2(cols) < 1) ? 1 : $clog2(cols);
  endfunction

  function automatic int riw(input int rows);
    return ($clog2(rows) < 1) ? 1 : $clog2(rows);
  endfunction

  function automatic int sumw(input int dw, input int cols);
    return dw + $clog2(cols + 1);
  endfunction

endpackage

// File: rtl/score_matrix_stream_if.sv
// Column-write and row-read handshakes of the score matrix streamer.
// rd_sum exists only when SCORE_ROW_SUM_EN is defined.
interface score_matrix_stream_if #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int DW   = 2
);
  import score_pkg::*;

  localparam int CIW  = ciw(COLS);
  localparam int RIW  = riw(ROWS);
  localparam int SUMW = sumw(DW, COLS);

  logic                           wr_valid;
  logic                           wr_ready;
  logic [CIW-1:0]                 wr_col;
  logic [ROWS-1:0][DW-1:0]        wr_data;
  logic                           rd_valid;
  logic                           rd_ready;
  logic [RIW-1:0]                 rd_row;
  logic [COLS-1:0][DW-1:0]        rd_data;
`ifdef SCORE_ROW_SUM_EN
  logic [SUMW-1:0]                rd_sum;
`endif

  // Producer/consumer side: drives writes, accepts rows.
  modport master (
    output wr_valid, wr_col, wr_data, rd_ready,
`ifdef SCORE_ROW_SUM_EN
    input  rd_sum,
`endif
    input  wr_ready, rd_valid, rd_row, rd_data
  );

  modport slave (
    input  wr_valid, wr_col, wr_data, rd_ready,
`ifdef SCORE_ROW_SUM_EN
    output rd_sum,
`endif
    output wr_ready, rd_valid, rd_row, rd_data
  );

endinterface

// File: rtl/score_matrix_stream_col_tracker.sv
// Tracks which columns have been written this round and classifies each write.
module score_col_tracker #(
  parameter int COLS = 10,
  parameter int CIW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_fire,
  input  logic            clr,
  input  logic [CIW-1:0]  wr_col,
  output logic [COLS-1:0] mask,
  output logic [COLS-1:0] next_mask,
  output logic            all_written,
  output logic            col_hit,
  output logic            dup_hit,
  output logic            range_hit
);

  logic [COLS-1:0] mask_q, mask_d;
  logic [COLS-1:0] onehot;

  always_comb begin
    range_hit = 1'b0;
    col_hit   = 1'b0;
    dup_hit   = 1'b0;
    onehot    = '0;
    if (wr_fire) begin
      if (int'(wr_col) >= COLS) begin
        range_hit = 1'b1;
      end else begin
        col_hit        = 1'b1;
        onehot[wr_col] = 1'b1;
        dup_hit        = mask_q[wr_col];
      end
    end
    next_mask   = mask_q | onehot;
    all_written = &next_mask;
    mask_d      = clr ? '0 : next_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign mask = mask_q;

endmodule

// File: rtl/score_matrix_stream.sv
// Collects ROWS x COLS scores column by column, then streams them out row by row.
// Define SCORE_ROW_SUM_EN to add a per-row sum (rd_sum) on the read port.
module score_matrix_stream
  import score_pkg::*;
#(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int DW   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  score_matrix_stream_if.slave              bus,
  input  logic                              abort,
  output logic                              done,
  output logic [ROWS-1:0][COLS-1:0][DW-1:0] matrix_out,
  output logic                              err_dup,
  output logic                              err_range
);

  localparam int CIW  = ciw(COLS);
  localparam int RIW  = riw(ROWS);
  localparam int SUMW = sumw(DW, COLS);

  score_state_e state_q, state_d;
  logic done_q, done_d, rd_valid_q, rd_valid_d;
  logic [RIW-1:0] rd_row_q, rd_row_d;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] matrix_q, matrix_d;
  logic err_dup_q, err_dup_d, err_range_q, err_range_d;

  logic wr_ready, wr_fire, rd_fire, drain_end;
  logic [COLS-1:0] mask, next_mask;
  logic all_written, col_hit, dup_hit, range_hit;

  assign wr_fire   = bus.wr_valid & wr_ready & ~abort;
  assign rd_fire   = rd_valid_q & bus.rd_ready;
  assign drain_end = rd_fire & (rd_row_q == RIW'(ROWS - 1));

  score_col_tracker #(.COLS(COLS), .CIW(CIW)) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .wr_fire     (wr_fire),
    .clr         (abort | drain_end),
    .wr_col      (bus.wr_col),
    .mask        (mask),
    .next_mask   (next_mask),
    .all_written (all_written),
    .col_hit     (col_hit),
    .dup_hit     (dup_hit),
    .range_hit   (range_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // abort outranks both the fill exit and the end of the drain.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL:  if (all_written) state_d = S_DRAIN;
        S_DRAIN: if (drain_end)   state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    wr_ready    = (state_q == S_FILL);
    bus.rd_data = matrix_q[rd_row_q];
  end

  always_comb begin
    matrix_d    = matrix_q;
    done_d      = done_q;
    rd_valid_d  = rd_valid_q;
    rd_row_d    = rd_row_q;
    err_dup_d   = err_dup_q | dup_hit;
    err_range_d = err_range_q | range_hit;
    if (col_hit) begin
      for (int r = 0; r < ROWS; r++) matrix_d[r][bus.wr_col] = bus.wr_data[r];
    end
    if (abort || drain_end) begin
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      rd_row_d   = '0;
    end else if (state_q == S_FILL && all_written) begin
      done_d     = 1'b1;
      rd_valid_d = 1'b1;
      rd_row_d   = '0;
    end else if (rd_fire) begin
      rd_row_d = rd_row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_q    <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_row_q    <= '0;
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      matrix_q    <= matrix_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_row_q    <= rd_row_d;
      err_dup_q   <= err_dup_d;
      err_range_q <= err_range_d;
    end
  end

`ifdef SCORE_ROW_SUM_EN
  logic [ROWS-1:0][SUMW-1:0] row_sum_q, row_sum_d;
  logic [SUMW-1:0] rd_sum_q, rd_sum_d;
  logic [SUMW-1:0] base;

  // Sums restart on the first write of a round; a rewrite backs out the old entry.
  always_comb begin
    row_sum_d = row_sum_q;
    base      = '0;
    if (col_hit) begin
      for (int r = 0; r < ROWS; r++) begin
        base = (mask == '0) ? '0 : row_sum_q[r];
        if (dup_hit) base = base - SUMW'(matrix_q[r][bus.wr_col]);
        row_sum_d[r] = base + SUMW'(bus.wr_data[r]);
      end
    end
    rd_sum_d = row_sum_d[rd_row_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sum_q <= '0;
      rd_sum_q  <= '0;
    end else begin
      row_sum_q <= row_sum_d;
      rd_sum_q  <= rd_sum_d;
    end
  end

  assign bus.rd_sum = rd_sum_q;
`endif

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_row   = rd_row_q;
  assign done         = done_q;
  assign matrix_out   = matrix_q;
  assign err_dup      = err_dup_q;
  assign err_range    = err_range_q;

endmodule

// File: tb/tb_score_matrix_stream.sv
// Directed self-checking bench for score_matrix_stream (10x10, DW=2).
module tb_score_matrix_stream;
  import score_pkg::*;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int DW   = 2;
  localparam int CIW  = ciw(COLS);

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic done, err_dup, err_range;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] matrix_out;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] exp_m;
  logic [ROWS-1:0][DW-1:0] data;
  int checks = 0;
  int failures = 0;

  score_matrix_stream_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();

  score_matrix_stream #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .abort      (abort),
    .done       (done),
    .matrix_out (matrix_out),
    .err_dup    (err_dup),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one column write for a single cycle; update the expected matrix if it should land.
  task automatic applyStimulus(input int col, input logic [ROWS-1:0][DW-1:0] d, input bit lands);
    bus.wr_valid = 1'b1;
    bus.wr_col   = CIW'(col);
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
    if (lands) for (int r = 0; r < ROWS; r++) exp_m[r][col] = d[r];
  endtask

  task automatic drainRows(input int exp_sum);
    bus.rd_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      checkOutput($sformatf("rd_valid_r%0d", r), 512'(bus.rd_valid), 512'(1));
      checkOutput($sformatf("rd_row_r%0d", r), 512'(bus.rd_row), 512'(r));
      checkOutput($sformatf("rd_data_r%0d", r), 512'(bus.rd_data), 512'(exp_m[r]));
`ifdef SCORE_ROW_SUM_EN
      if (exp_sum >= 0) checkOutput($sformatf("rd_sum_r%0d", r), 512'(bus.rd_sum), 512'(exp_sum));
`endif
      step();
    end
    bus.rd_ready = 1'b0;
    checkOutput("drain_done_low", 512'(done), 512'(0));
    checkOutput("drain_wr_ready", 512'(bus.wr_ready), 512'(1));
    checkOutput("drain_rd_valid_low", 512'(bus.rd_valid), 512'(0));
  endtask

  initial begin
    int order[11] = '{9, 3, 0, 3, 1, 2, 4, 5, 6, 7, 8};
    bit seen3;
    rst = 1'b1;
    abort = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_col = '0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    exp_m = '0;
    #12 rst = 1'b0;
    step();

    checkOutput("rst_wr_ready", 512'(bus.wr_ready), 512'(1));
    checkOutput("rst_done", 512'(done), 512'(0));
    checkOutput("rst_rd_valid", 512'(bus.rd_valid), 512'(0));
    checkOutput("rst_rd_row", 512'(bus.rd_row), 512'(0));
    checkOutput("rst_matrix", 512'(matrix_out), 512'(0));
    checkOutput("rst_errs", 512'({err_dup, err_range}), 512'(0));

    // Round 1: in-order fill, every row r holds r%4.
    bus.rd_ready = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) data[r] = DW'(r % 4);
      applyStimulus(c, data, 1'b1);
      checkOutput($sformatf("r1_done_c%0d", c), 512'(done), 512'(c == COLS - 1));
    end
    checkOutput("r1_matrix", 512'(matrix_out), 512'(exp_m));
    drainRows(-1);

    // Round 2: out-of-order fill with a duplicate column and an out-of-range write.
    seen3 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < ROWS; r++) data[r] = DW'((order[i] == 3 && seen3) ? (r + 2) % 4 : (r + order[i] + 1) % 4);
      if (order[i] == 3) seen3 = 1'b1;
      applyStimulus(order[i], data, 1'b1);
      checkOutput($sformatf("r2_done_i%0d", i), 512'(done), 512'(i == 10));
      if (i == 0) begin
        data = '1;
        applyStimulus(12, data, 1'b0);
        checkOutput("range_flag", 512'(err_range), 512'(1));
        checkOutput("range_no_write", 512'(matrix_out), 512'(exp_m));
        checkOutput("range_no_dup", 512'(err_dup), 512'(0));
        checkOutput("range_done", 512'(done), 512'(0));
      end
      if (i == 3) checkOutput("dup_flag", 512'(err_dup), 512'(1));
    end
    checkOutput("r2_matrix", 512'(matrix_out), 512'(exp_m));
    checkOutput("r2_col3_second", 512'(matrix_out[1][3]), 512'(3));

    bus.rd_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      checkOutput($sformatf("r2_row_%0d", r), 512'(bus.rd_row), 512'(r));
      step();
    end
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.wr_valid = 1'b1;
        bus.wr_col = '0;
        bus.wr_data = '1;
      end
      step();
      bus.wr_valid = 1'b0;
      checkOutput($sformatf("stall_valid_%0d", k), 512'(bus.rd_valid), 512'(1));
      checkOutput($sformatf("stall_row_%0d", k), 512'(bus.rd_row), 512'(4));
      checkOutput($sformatf("stall_data_%0d", k), 512'(bus.rd_data), 512'(exp_m[4]));
      checkOutput($sformatf("stall_wr_ready_%0d", k), 512'(bus.wr_ready), 512'(0));
    end
    checkOutput("stall_write_ignored", 512'(matrix_out), 512'(exp_m));
    bus.rd_ready = 1'b1;
    step();
    checkOutput("resume_row5", 512'(bus.rd_row), 512'(5));
    checkOutput("resume_data5", 512'(bus.rd_data), 512'(exp_m[5]));
    step();
    checkOutput("resume_row6", 512'(bus.rd_row), 512'(6));
    bus.rd_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_wr_ready", 512'(bus.wr_ready), 512'(1));
    checkOutput("abort_done", 512'(done), 512'(0));
    checkOutput("abort_rd_valid", 512'(bus.rd_valid), 512'(0));
    checkOutput("abort_rd_row", 512'(bus.rd_row), 512'(0));
    checkOutput("abort_matrix", 512'(matrix_out), 512'(exp_m));
    checkOutput("abort_errs_sticky", 512'({err_dup, err_range}), 512'(3));

    // Round 3: a lone write must not complete the round, then async reset mid-fill.
    data = '0;
    applyStimulus(5, data, 1'b1);
    checkOutput("abort_mask_empty", 512'(done), 512'(0));
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < ROWS; r++) data[r] = DW'((r + c) % 4);
      applyStimulus(c, data, 1'b1);
    end
    checkOutput("r3_matrix", 512'(matrix_out), 512'(exp_m));
    #3 rst = 1'b1;
    #1;
    checkOutput("async_matrix", 512'(matrix_out), 512'(0));
    checkOutput("async_errs", 512'({err_dup, err_range}), 512'(0));
    checkOutput("async_done", 512'(done), 512'(0));
    checkOutput("async_wr_ready", 512'(bus.wr_ready), 512'(1));
    @(negedge clk);
    rst = 1'b0;
    exp_m = '0;
    step();

    // Round 4: all entries 3.
    for (int c = 0; c < COLS; c++) begin
      data = '1;
      applyStimulus(c, data, 1'b1);
    end
    checkOutput("r4_done", 512'(done), 512'(1));
    drainRows(30);

    // Round 5: column 0 rewritten with 1s.
    for (int c = 0; c < COLS - 1; c++) begin
      data = '1;
      applyStimulus(c, data, 1'b1);
    end
    for (int r = 0; r < ROWS; r++) data[r] = DW'(1);
    applyStimulus(0, data, 1'b1);
    checkOutput("r5_dup", 512'(err_dup), 512'(1));
    checkOutput("r5_not_done", 512'(done), 512'(0));
    data = '1;
    applyStimulus(COLS - 1, data, 1'b1);
    checkOutput("r5_done", 512'(done), 512'(1));
    drainRows(28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
